// File: rtl/ccff_config_loader.sv
// ccff_config_loader: holds the fabric in reset, pulses pReset, streams the bitstream MSB first
// into ccff_head under a gated prog_clk, then releases the fabric. CCFF_CRC_EN adds a CRC-16 check.
module ccff_config_loader #(
   parameter int CHAIN_LEN     = 2282,
   parameter int WORD_W        = 32,
   parameter int PRESET_CYCLES = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [WORD_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              prog_clk_en,
   output logic              ccff_head,
   output logic              pReset_o,
   output logic              fpga_reset,
   output logic              user_clk_en,
   output logic              busy,
   output logic              done
`ifdef CCFF_CRC_EN
   ,
   output logic              crc_err
`endif
);

   localparam int CNT_W   = $clog2(CHAIN_LEN + 1);
   localparam int CW1     = CNT_W + 1;
   localparam int REM_W   = $clog2(WORD_W + 1);
   localparam int DLY_MAX = (PRESET_CYCLES > SETTLE_CYCLES) ? PRESET_CYCLES : SETTLE_CYCLES;
   localparam int DLY_W   = $clog2(DLY_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESET,
      ST_LOAD,
      ST_SETTLE,
`ifdef CCFF_CRC_EN
      ST_CHECK,
`endif
      ST_RELEASE
   } state_t;

   state_t            state, state_d;
   logic [DLY_W-1:0]  dly_cnt, dly_d;
   logic [CNT_W-1:0]  shift_cnt, shift_cnt_d, shift_done;
   logic [WORD_W-1:0] sreg, sreg_d;
   logic [REM_W-1:0]  rem, rem_d;
   logic              head_d, pce_d, s_ready_d, preset_d, frst_d, uce_d, busy_d, done_d;
   logic              handshake;

`ifdef CCFF_CRC_EN
   logic [15:0] crc, crc_d;
   logic        crc_err_d;

   function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction
`endif

   assign handshake = s_valid & s_ready;

   // Next-state and next-output logic; rem counts bits still waiting in sreg behind ccff_head.
   always_comb begin
      state_d     = state;
      dly_d       = dly_cnt;
      shift_cnt_d = shift_cnt;
      sreg_d      = sreg;
      rem_d       = rem;
      head_d      = ccff_head;
      pce_d       = 1'b0;
      preset_d    = pReset_o;
      frst_d      = fpga_reset;
      uce_d       = user_clk_en;
      busy_d      = busy;
      done_d      = done;
`ifdef CCFF_CRC_EN
      crc_d       = crc;
      crc_err_d   = crc_err;
`endif
      shift_done  = shift_cnt + CNT_W'(prog_clk_en);

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_PRESET;
               dly_d       = '0;
               shift_cnt_d = '0;
               rem_d       = '0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               frst_d      = 1'b1;
               uce_d       = 1'b0;
               preset_d    = 1'b1;
`ifdef CCFF_CRC_EN
               crc_d       = 16'hFFFF;
               crc_err_d   = 1'b0;
`endif
            end
         end
         ST_PRESET: begin
            if (dly_cnt == DLY_W'(PRESET_CYCLES - 1)) begin
               preset_d = 1'b0;
               state_d  = ST_LOAD;
            end else begin
               dly_d = dly_cnt + 1'b1;
            end
         end
         ST_LOAD: begin
            shift_cnt_d = shift_done;
`ifdef CCFF_CRC_EN
            if (prog_clk_en)
               crc_d = crc16_step(crc, ccff_head);
`endif
            // Leftover bits of the final word are simply abandoned in sreg.
            if (shift_done == CNT_W'(CHAIN_LEN)) begin
               state_d = ST_SETTLE;
               dly_d   = '0;
            end else if (rem != '0) begin
               head_d = sreg[WORD_W-1];
               sreg_d = sreg << 1;
               rem_d  = rem - 1'b1;
               pce_d  = 1'b1;
            end else if (handshake) begin
               head_d = s_data[WORD_W-1];
               sreg_d = s_data << 1;
               rem_d  = REM_W'(WORD_W - 1);
               pce_d  = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (dly_cnt == DLY_W'(SETTLE_CYCLES - 1)) begin
`ifdef CCFF_CRC_EN
               state_d = ST_CHECK;
`else
               state_d = ST_RELEASE;
               frst_d  = 1'b0;
               uce_d   = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
`endif
            end else begin
               dly_d = dly_cnt + 1'b1;
            end
         end
`ifdef CCFF_CRC_EN
         ST_CHECK: begin
            if (handshake) begin
               if (16'(s_data) == crc) begin
                  state_d = ST_RELEASE;
                  frst_d  = 1'b0;
                  uce_d   = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d   = ST_IDLE;
                  crc_err_d = 1'b1;
                  busy_d    = 1'b0;
                  done_d    = 1'b0;
               end
            end
         end
`endif
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Ask for a word only when sreg will be empty and the chain still needs bits after this cycle.
      s_ready_d = (state_d == ST_LOAD) && (rem_d == '0) &&
                  (({1'b0, shift_cnt_d} + CW1'(pce_d)) < CW1'(CHAIN_LEN));
`ifdef CCFF_CRC_EN
      if (state_d == ST_CHECK)
         s_ready_d = 1'b1;
`endif
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         dly_cnt     <= '0;
         shift_cnt   <= '0;
         sreg        <= '0;
         rem         <= '0;
         ccff_head   <= 1'b0;
         prog_clk_en <= 1'b0;
         s_ready     <= 1'b0;
         pReset_o    <= 1'b1;
         fpga_reset  <= 1'b1;
         user_clk_en <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
`ifdef CCFF_CRC_EN
         crc         <= 16'hFFFF;
         crc_err     <= 1'b0;
`endif
      end else begin
         state       <= state_d;
         dly_cnt     <= dly_d;
         shift_cnt   <= shift_cnt_d;
         sreg        <= sreg_d;
         rem         <= rem_d;
         ccff_head   <= head_d;
         prog_clk_en <= pce_d;
         s_ready     <= s_ready_d;
         pReset_o    <= preset_d;
         fpga_reset  <= frst_d;
         user_clk_en <= uce_d;
         busy        <= busy_d;
         done        <= done_d;
`ifdef CCFF_CRC_EN
         crc         <= crc_d;
         crc_err     <= crc_err_d;
`endif
      end
   end

endmodule

// File: tb/tb_ccff_config_loader.sv
// Testbench for ccff_config_loader: table of full configuration runs on the default-size
// instance plus hand-written sequences for reset and a 5-bit chain instance.
module tb_ccff_config_loader;

   localparam int CHAIN  = 2282;
   localparam int N_DATA = 72;
`ifdef CCFF_CRC_EN
   localparam int CRC_EXTRA  = 1;
   localparam int SETTLE_EXP = 3;
`else
   localparam int CRC_EXTRA  = 0;
   localparam int SETTLE_EXP = 2;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready, prog_clk_en, ccff_head, pReset_o, fpga_reset, user_clk_en, busy, done;
   logic        crc_err_w;

   logic        sm_start = 1'b0;
   logic [7:0]  sm_data = '0;
   logic        sm_valid = 1'b0;
   logic        sm_ready, sm_pce, sm_head, sm_preset, sm_frst, sm_uce, sm_busy, sm_done;
   logic        sm_crc_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

`ifndef CCFF_CRC_EN
   assign crc_err_w  = 1'b0;
   assign sm_crc_err = 1'b0;
`endif

   ccff_config_loader dut (
      .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .prog_clk_en(prog_clk_en), .ccff_head(ccff_head), .pReset_o(pReset_o),
      .fpga_reset(fpga_reset), .user_clk_en(user_clk_en), .busy(busy), .done(done)
`ifdef CCFF_CRC_EN
      , .crc_err(crc_err_w)
`endif
   );

   ccff_config_loader #(.CHAIN_LEN(5), .WORD_W(8)) dut_sm (
      .clk(clk), .reset(reset), .start(sm_start), .s_data(sm_data), .s_valid(sm_valid),
      .s_ready(sm_ready), .prog_clk_en(sm_pce), .ccff_head(sm_head), .pReset_o(sm_preset),
      .fpga_reset(sm_frst), .user_clk_en(sm_uce), .busy(sm_busy), .done(sm_done)
`ifdef CCFF_CRC_EN
      , .crc_err(sm_crc_err)
`endif
   );

   typedef struct {
      int pattern;
      int stall_word;
      int stall_len;
      int glitch_at;
      int reset_at;
      bit bad_crc;
      int exp_shifts;
      int exp_words;
      int exp_gap;
      int exp_preset;
      int exp_settle;
      bit exp_done;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] word_of(input int pattern, input int idx);
      if (pattern == 0)
         return (idx % 2 == 0) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A;
      return 32'h1234_5678 ^ (32'(idx) * 32'h0101_0101);
   endfunction

   // Reference CRC-16-CCITT, one message bit at a time (MSB-first division).
   function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
      logic [16:0] r;
      r = {c, 1'b0};
      if (c[15] ^ b)
         r = r ^ 17'h1_1021;
      return r[15:0];
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      int shifts = 0, words = 0, head_err = 0, stable_err = 0, gap = 0, pending = 0;
      int preset_cnt = 0, settle = 0, stalled = 0;
      bit finished = 0, glitched = 0;
      logic prev_head = 1'b0;
      logic exp_bit;
      logic [31:0] w;
      logic [15:0] crc_m = 16'hFFFF;

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_output("start_state", {busy, fpga_reset, user_clk_en, done, pReset_o}, 5'b11001);

      for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
         if (cyc > 0) @(negedge clk);
         start = 1'b0;
         if (pReset_o && busy) preset_cnt++;
         if (shifts >= CHAIN && fpga_reset) settle++;
         if (prog_clk_en) begin
            if (shifts < CHAIN) begin
               w = word_of(v.pattern, shifts / 32);
               exp_bit = w[31 - (shifts % 32)];
               if (ccff_head !== exp_bit) head_err++;
               crc_m = crc_bit(crc_m, exp_bit);
            end
            shifts++;
            gap += pending;
            pending = 0;
         end else if (shifts > 0 && shifts < CHAIN) begin
            pending++;
            if (ccff_head !== prev_head) stable_err++;
         end
         prev_head = ccff_head;

         if (v.reset_at >= 0 && shifts == v.reset_at) begin
            reset = 1'b1;
            #1;
            check_output("reset_mid_load",
               {pReset_o, fpga_reset, prog_clk_en, ccff_head, user_clk_en, s_ready, busy, done, crc_err_w},
               9'b1100_0000_0);
            #1;
            reset = 1'b0;
            s_valid = 1'b0;
            return;
         end

         if (done || crc_err_w) begin
            finished = 1;
            s_valid = 1'b0;
         end else begin
            if (v.glitch_at >= 0 && shifts == v.glitch_at && !glitched) begin
               start = 1'b1;
               glitched = 1;
            end
            if (v.stall_len > 0 && words == v.stall_word + 1 && stalled < v.stall_len && s_ready) begin
               s_valid = 1'b0;
               stalled++;
            end else begin
               s_valid = (words < N_DATA + CRC_EXTRA);
               if (words < N_DATA)
                  s_data = word_of(v.pattern, words);
               else
                  s_data = v.bad_crc ? 32'h0 : {16'h0, crc_m};
               if (s_valid && s_ready) words++;
            end
         end
      end

      if (!finished) check_output("completion_timeout", 0, 1);
      check_output("shift_count", shifts, v.exp_shifts);
      check_output("words_consumed", words, v.exp_words + CRC_EXTRA);
      check_output("head_bit_errors", head_err, 0);
      check_output("stall_head_changes", stable_err, 0);
      check_output("shift_gap_cycles", gap, v.exp_gap);
      check_output("preset_cycles", preset_cnt, v.exp_preset);
      if (v.exp_done) check_output("settle_cycles", settle, v.exp_settle);
      check_output("done", done, v.exp_done);
      check_output("user_clk_en", user_clk_en, v.exp_done);
      check_output("fpga_reset", fpga_reset, !v.exp_done);
      check_output("busy_end", busy, 0);
      check_output("crc_err", crc_err_w, (CRC_EXTRA == 1) && !v.exp_done);
   endtask

   task automatic small_chain_test();
      int shifts = 0, words = 0;
      bit finished = 0;
      logic [15:0] seq = '0;
      logic [15:0] crc_s = 16'hFFFF;
      logic [4:0]  bits = 5'b11110;
      bit exp_done = (CRC_EXTRA == 0);

      for (int i = 4; i >= 0; i--) crc_s = crc_bit(crc_s, bits[i]);
      @(negedge clk);
      sm_start = 1'b1;
      @(negedge clk);
      sm_start = 1'b0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (sm_pce) begin
            seq = {seq[14:0], sm_head};
            shifts++;
         end
         if (sm_done || sm_crc_err) begin
            finished = 1;
            sm_valid = 1'b0;
         end else begin
            sm_valid = 1'b1;
            sm_data = (words == 0) ? 8'hF0 : ~crc_s[7:0];
            if (sm_valid && sm_ready) words++;
         end
      end
      if (!finished) check_output("small_timeout", 0, 1);
      check_output("small_shifts", shifts, 5);
      check_output("small_head_seq", seq[4:0], 5'b11110);
      check_output("small_words", words, 1 + CRC_EXTRA);
      check_output("small_done", sm_done, exp_done);
      check_output("small_crc_err", sm_crc_err, !exp_done);
   endtask

   initial begin
      vecs.push_back('{0, -1, 0, -1,   -1, 1'b0, 2282, 72, 0, 4, SETTLE_EXP, 1'b1});
      vecs.push_back('{1, 10, 5, -1,   -1, 1'b0, 2282, 72, 5, 4, SETTLE_EXP, 1'b1});
      vecs.push_back('{0, -1, 0, 500,  -1, 1'b0, 2282, 72, 0, 4, SETTLE_EXP, 1'b1});
      vecs.push_back('{1, -1, 0, -1, 1000, 1'b0, 2282, 72, 0, 4, SETTLE_EXP, 1'b1});
      vecs.push_back('{1, -1, 0, -1,   -1, 1'b0, 2282, 72, 0, 4, SETTLE_EXP, 1'b1});
`ifdef CCFF_CRC_EN
      vecs.push_back('{0, -1, 0, -1,   -1, 1'b1, 2282, 72, 0, 4, SETTLE_EXP, 1'b0});
`endif

      #12;
      check_output("reset_big",
         {pReset_o, fpga_reset, prog_clk_en, ccff_head, user_clk_en, s_ready, busy, done, crc_err_w},
         9'b1100_0000_0);
      check_output("reset_small",
         {sm_preset, sm_frst, sm_pce, sm_head, sm_uce, sm_ready, sm_busy, sm_done, sm_crc_err},
         9'b1100_0000_0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) apply_stimulus(vecs[i]);
      small_chain_test();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
